// File: rtl/mii_sched_pkg.sv
// Shared types and constants for the MII transmit scheduler.
package mii_sched_pkg;

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned MODE_W = 8;

    localparam int unsigned DEF_N_REQ            = 4;
    localparam int unsigned DEF_PAYLOAD_MAX_SIZE = 1500;
    localparam int unsigned DEF_START_CYCLES     = 2;
    localparam int unsigned DEF_IFG_CYCLES       = 12;
    localparam int unsigned DEF_TIMEOUT_CYCLES   = 4096;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitTx,
        StTx,
        StIfg
    } sched_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request after the last winner, with wraparound.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        pos     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            pos = IDX_W'((32'(i_last) + k) % N);
            if (!o_valid && i_req[pos]) begin
                o_valid      = 1'b1;
                o_idx        = pos;
                o_grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mii_tx_scheduler.sv
// Shares one MAC frame generator between N_REQ requesters with round-robin arbitration,
// length checking, inter-frame gap and stall timeout.
module mii_tx_scheduler
    import mii_sched_pkg::*;
#(
    parameter int unsigned N_REQ            = DEF_N_REQ,
    parameter int unsigned PAYLOAD_MAX_SIZE = DEF_PAYLOAD_MAX_SIZE,
    parameter int unsigned START_CYCLES     = DEF_START_CYCLES,
    parameter int unsigned IFG_CYCLES       = DEF_IFG_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [LEN_W*N_REQ-1:0]  i_payload_length,
    input  logic [MODE_W*N_REQ-1:0] i_mode,
    input  logic                    i_tx_valid,
    output logic                    o_start,
    output logic [LEN_W-1:0]        o_payload_length,
    output logic [MODE_W-1:0]       o_mode,
    output logic [N_REQ-1:0]        o_grant,
    output logic [N_REQ-1:0]        o_done,
    output logic [N_REQ-1:0]        o_reject,
    output logic                    o_timeout,
    output logic                    o_busy,
    output logic [31:0]             o_frame_count
);

    localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    // Counter is shared by START, WAIT_TX/TX and IFG phases.
    localparam int unsigned CNT_MAX = max_u(max_u(TIMEOUT_CYCLES, IFG_CYCLES), START_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'((START_CYCLES > 0) ? START_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] IFG_LAST     = CNT_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam sched_state_e     AFTER_FRAME  = (IFG_CYCLES == 0) ? StIdle : StIfg;

    sched_state_e        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [N_REQ-1:0]    reject_q, reject_d;
    logic                timeout_q, timeout_d;
    logic [31:0]         count_q, count_d;

    logic [N_REQ-1:0]    arb_grant;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_valid;
    logic [LEN_W-1:0]    win_len;
    logic [MODE_W-1:0]   win_mode;
    logic                win_len_ok;

    rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req   (i_req),
        .i_last  (last_q),
        .o_grant (arb_grant),
        .o_idx   (arb_idx),
        .o_valid (arb_valid)
    );

    always_comb begin
        win_len  = '0;
        win_mode = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                win_len  = i_payload_length[i*LEN_W +: LEN_W];
                win_mode = i_mode[i*MODE_W +: MODE_W];
            end
        end
        win_len_ok = (win_len != '0) && (win_len <= LEN_W'(PAYLOAD_MAX_SIZE));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        grant_d   = grant_q;
        len_d     = len_q;
        mode_d    = mode_q;
        done_d    = '0;
        reject_d  = '0;
        timeout_d = 1'b0;
        count_d   = count_q;
        unique case (state_q)
            StIdle: begin
                if (i_enable && arb_valid) begin
                    last_d = arb_idx;
                    if (win_len_ok) begin
                        grant_d = arb_grant;
                        len_d   = win_len;
                        mode_d  = win_mode;
                        cnt_d   = '0;
                        state_d = StStart;
                    end else begin
                        reject_d = arb_grant;
                    end
                end
            end
            StStart: begin
                if (cnt_q == START_LAST) begin
                    cnt_d   = '0;
                    state_d = StWaitTx;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitTx: begin
                if (i_tx_valid) begin
                    cnt_d   = '0;
                    state_d = StTx;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    cnt_d     = '0;
                    state_d   = AFTER_FRAME;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StTx: begin
                if (!i_tx_valid) begin
                    done_d  = grant_q;
                    count_d = count_q + 32'd1;
                    grant_d = '0;
                    cnt_d   = '0;
                    state_d = AFTER_FRAME;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    cnt_d     = '0;
                    state_d   = AFTER_FRAME;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StIfg: begin
                if (cnt_q == IFG_LAST) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            grant_q   <= '0;
            len_q     <= '0;
            mode_q    <= '0;
            done_q    <= '0;
            reject_q  <= '0;
            timeout_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
            reject_q  <= reject_d;
            timeout_q <= timeout_d;
            count_q   <= count_d;
        end
    end

    assign o_start          = (state_q == StStart);
    assign o_busy           = (state_q != StIdle);
    assign o_payload_length = len_q;
    assign o_mode           = mode_q;
    assign o_grant          = grant_q;
    assign o_done           = done_q;
    assign o_reject         = reject_q;
    assign o_timeout        = timeout_q;
    assign o_frame_count    = count_q;

endmodule
